// File: rtl/usb_rx_packet_ctrl.sv
// USB receive packet sequencer: SYNC/PID check, token decode with CRC5, data payload to RX FIFO.
// Outputs registered, one cycle behind the deciding state; fifo_full on a data byte aborts the packet.
module usb_rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int unsigned MAX_BYTES = 66
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic [6:0] dev_addr,
  input  logic       fifo_full,
  output logic       rcving,
  output logic       w_enable,
  output logic [3:0] pid,
  output logic       token_valid,
  output logic [3:0] token_endp,
  output logic       data_done,
  output logic [6:0] byte_count,
  output logic       r_error
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  typedef enum logic [3:0] {
    IDLE,
    SYNC_WAIT,
    SYNC_CHK,
    PID_WAIT,
    PID_CHK,
    TOK1_WAIT,
    TOK2_WAIT,
    TOK_CHK,
    TOK_EOP,
    DATA_WAIT,
    DATA_WR,
    DATA_DONE,
    HS_EOP,
    ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_byte0;
  logic [7:0]  r_byte1;
  logic        r_eop_low;
  logic [10:0] w_field;
  logic [4:0]  w_crc;
  logic        w_crc_ok;
  logic        w_pid_ok;
  logic        w_addr_hit;

  assign w_field    = {r_byte1[2:0], r_byte0};
  assign w_crc_ok   = (~w_crc == r_byte1[7:3]);
  assign w_pid_ok   = (rcv_data[7:4] == ~rcv_data[3:0]);
  assign w_addr_hit = (w_field[6:0] == dev_addr);

  // Serial CRC5 over the 11-bit address/endpoint field, least significant bit first.
  always_comb begin
    w_crc = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      if (w_crc[4] ^ w_field[i]) begin
        w_crc = {w_crc[3:0], 1'b0} ^ 5'b00101;
      end else begin
        w_crc = {w_crc[3:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (d_edge) w_next = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (byte_received) w_next = SYNC_CHK;
        else if (eop)      w_next = ERR;
      end
      SYNC_CHK: begin
        w_next = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
      end
      PID_WAIT: begin
        if (byte_received) w_next = PID_CHK;
        else if (eop)      w_next = ERR;
      end
      PID_CHK: begin
        if (!w_pid_ok) begin
          w_next = ERR;
        end else begin
          case (rcv_data[3:0])
            4'b0001, 4'b1001, 4'b1101: w_next = TOK1_WAIT;
            4'b0011, 4'b1011:          w_next = DATA_WAIT;
            4'b0010, 4'b1010, 4'b1110: w_next = HS_EOP;
            default:                   w_next = ERR;
          endcase
        end
      end
      TOK1_WAIT: begin
        if (byte_received) w_next = TOK2_WAIT;
        else if (eop)      w_next = ERR;
      end
      TOK2_WAIT: begin
        if (byte_received) w_next = TOK_CHK;
        else if (eop)      w_next = ERR;
      end
      TOK_CHK: begin
        w_next = w_crc_ok ? TOK_EOP : ERR;
      end
      TOK_EOP: begin
        if (byte_received) w_next = ERR;
        else if (eop)      w_next = IDLE;
      end
      DATA_WAIT: begin
        // A packet shorter than its CRC16 cannot be valid data.
        if (byte_received) w_next = DATA_WR;
        else if (eop)      w_next = (byte_count >= 7'd2) ? DATA_DONE : ERR;
      end
      DATA_WR: begin
        w_next = (fifo_full || byte_count == MAX_CNT) ? ERR : DATA_WAIT;
      end
      DATA_DONE: begin
        w_next = IDLE;
      end
      HS_EOP: begin
        if (byte_received) w_next = ERR;
        else if (eop)      w_next = IDLE;
      end
      ERR: begin
        if (r_eop_low && d_edge) w_next = SYNC_WAIT;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_byte0     <= 8'd0;
      r_byte1     <= 8'd0;
      r_eop_low   <= 1'b0;
      rcving      <= 1'b0;
      w_enable    <= 1'b0;
      pid         <= 4'd0;
      token_valid <= 1'b0;
      token_endp  <= 4'd0;
      data_done   <= 1'b0;
      byte_count  <= 7'd0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_next;
      rcving      <= (w_next != IDLE) && (w_next != ERR);
      w_enable    <= (r_state == DATA_WR) && (w_next == DATA_WAIT);
      data_done   <= (w_next == DATA_DONE);
      token_valid <= (r_state == TOK_EOP) && (w_next == IDLE) && w_addr_hit;

      // The bus must go quiet for a cycle before a new packet may leave ERR.
      r_eop_low <= (r_state == ERR) && (r_eop_low || !eop);

      if (r_state == TOK1_WAIT && byte_received) r_byte0 <= rcv_data;
      if (r_state == TOK2_WAIT && byte_received) r_byte1 <= rcv_data;

      if (r_state == TOK_EOP && w_next == IDLE && w_addr_hit) begin
        token_endp <= w_field[10:7];
      end

      if (r_state == PID_CHK && w_pid_ok) pid <= rcv_data[3:0];

      if (r_state == PID_CHK && w_next == DATA_WAIT) begin
        byte_count <= 7'd0;
      end else if (r_state == DATA_WR && w_next == DATA_WAIT) begin
        byte_count <= byte_count + 7'd1;
      end

      if (w_next == ERR) begin
        r_error <= 1'b1;
      end else if (r_state == ERR && w_next == SYNC_WAIT) begin
        r_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Directed bench for usb_rx_packet_ctrl: tokens, data packets, handshake, error and reset cases.
module tb_usb_rx_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_edge;
  logic       eop;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic [6:0] dev_addr;
  logic       fifo_full;
  logic       rcving;
  logic       w_enable;
  logic [3:0] pid;
  logic       token_valid;
  logic [3:0] token_endp;
  logic       data_done;
  logic [6:0] byte_count;
  logic       r_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_we = 0;
  int n_tv = 0;
  int n_dd = 0;
  logic [7:0] wr_q[$];

  always #5 clk = ~clk;

  usb_rx_packet_ctrl #(.SYNC_BYTE(8'h80), .MAX_BYTES(66)) dut (
    .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop),
    .byte_received(byte_received), .rcv_data(rcv_data), .dev_addr(dev_addr),
    .fifo_full(fifo_full), .rcving(rcving), .w_enable(w_enable), .pid(pid),
    .token_valid(token_valid), .token_endp(token_endp), .data_done(data_done),
    .byte_count(byte_count), .r_error(r_error)
  );

  // Strobes are counted at the edge that ends the cycle they were high in.
  always @(posedge clk) begin
    if (w_enable) begin
      n_we <= n_we + 1;
      wr_q.push_back(rcv_data);
    end
    if (token_valid) n_tv <= n_tv + 1;
    if (data_done)   n_dd <= n_dd + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rcv_data      = b;
    byte_received = 1'b1;
    cyc(1);
    byte_received = 1'b0;
    cyc(3);
  endtask

  task automatic start_pkt();
    d_edge = 1'b1;
    cyc(1);
    d_edge = 1'b0;
    cyc(1);
  endtask

  task automatic end_pkt();
    eop = 1'b1;
    cyc(2);
    eop = 1'b0;
    cyc(2);
  endtask

  task automatic token(input logic [7:0] p, input logic [7:0] b0, input logic [7:0] b1);
    start_pkt();
    send(8'h80);
    send(p);
    send(b0);
    send(b1);
    end_pkt();
  endtask

  initial begin
    int tv0;
    int we0;
    int dd0;
    int q0;
    logic [7:0] payload [6];
    payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A};

    rst = 1'b1; d_edge = 1'b0; eop = 1'b0; byte_received = 1'b0;
    rcv_data = 8'h00; dev_addr = 7'd3; fifo_full = 1'b0;
    cyc(3);
    check("rst_rcving", rcving, 0);
    check("rst_wen", w_enable, 0);
    check("rst_pid", pid, 0);
    check("rst_tv", token_valid, 0);
    check("rst_endp", token_endp, 0);
    check("rst_dd", data_done, 0);
    check("rst_bc", byte_count, 0);
    check("rst_err", r_error, 0);
    rst = 1'b0;
    cyc(2);

    // OUT addr 3 endp 0; CRC5 of 11'h003 complemented is 5'b01010 -> byte1 8'h50.
    tv0 = n_tv;
    start_pkt();
    send(8'h80);
    check("out_rcving", rcving, 1);
    send(8'hE1);
    send(8'h03);
    send(8'h50);
    end_pkt();
    check("out_tv", n_tv - tv0, 1);
    check("out_endp", token_endp, 0);
    check("out_pid", pid, 1);
    check("out_err", r_error, 0);
    check("out_idle", rcving, 0);

    // IN addr 3 endp 1; field 11'h083 gives CRC bits 5'b00111 -> bytes 83 38.
    tv0 = n_tv;
    token(8'h69, 8'h83, 8'h38);
    check("in_tv", n_tv - tv0, 1);
    check("in_endp", token_endp, 1);
    check("in_pid", pid, 9);

    dev_addr = 7'd5;
    tv0 = n_tv;
    token(8'hE1, 8'h03, 8'h50);
    check("miss_tv", n_tv - tv0, 0);
    check("miss_err", r_error, 0);
    check("miss_idle", rcving, 0);
    check("miss_endp", token_endp, 1);

    // SETUP addr 0 endp 0; CRC bits 5'b01000 -> byte1 8'h40.
    dev_addr = 7'd0;
    tv0 = n_tv;
    token(8'h2D, 8'h00, 8'h40);
    check("setup_tv", n_tv - tv0, 1);
    check("setup_endp", token_endp, 0);
    check("setup_pid", pid, 4'hD);

    dev_addr = 7'd3;
    tv0 = n_tv;
    token(8'hE1, 8'h03, 8'h58);
    check("crc_tv", n_tv - tv0, 0);
    check("crc_err", r_error, 1);
    check("crc_rcving", rcving, 0);

    we0 = n_we; dd0 = n_dd; q0 = wr_q.size();
    start_pkt();
    check("err_clear", r_error, 0);
    send(8'h80);
    send(8'hC3);
    for (int i = 0; i < 6; i++) send(payload[i]);
    end_pkt();
    check("d0_writes", n_we - we0, 6);
    for (int i = 0; i < 6; i++) begin
      if (wr_q.size() > q0 + i) check("d0_byte", wr_q[q0 + i], payload[i]);
      else check("d0_byte_missing", 0, 1);
    end
    check("d0_bc", byte_count, 6);
    check("d0_dd", n_dd - dd0, 1);
    check("d0_pid", pid, 3);
    check("d0_err", r_error, 0);

    start_pkt();
    send(8'h80);
    send(8'hA5);
    check("badpid_err", r_error, 1);
    check("badpid_rcving", rcving, 0);
    check("badpid_pid", pid, 5);
    start_pkt();
    check("ack_err_clear", r_error, 0);
    check("ack_rcving", rcving, 1);
    send(8'h80);
    send(8'hD2);
    end_pkt();
    check("ack_pid", pid, 2);
    check("ack_err", r_error, 0);
    check("ack_idle", rcving, 0);

    we0 = n_we; dd0 = n_dd;
    start_pkt();
    send(8'h80);
    send(8'hC3);
    send(8'h77);
    end_pkt();
    check("short_err", r_error, 1);
    check("short_dd", n_dd - dd0, 0);
    check("short_writes", n_we - we0, 1);

    we0 = n_we;
    start_pkt();
    send(8'h80);
    send(8'hC3);
    send(8'h01);
    send(8'h02);
    fifo_full = 1'b1;
    send(8'h03);
    fifo_full = 1'b0;
    check("full_writes", n_we - we0, 2);
    check("full_err", r_error, 1);
    end_pkt();

    we0 = n_we; dd0 = n_dd;
    start_pkt();
    send(8'h80);
    send(8'h4B);
    for (int i = 0; i < 66; i++) send(8'(i));
    check("max_bc", byte_count, 66);
    check("max_err_before", r_error, 0);
    check("max_pid", pid, 4'hB);
    check("max_last", wr_q[wr_q.size() - 1], 8'h41);
    send(8'h99);
    check("over_err", r_error, 1);
    check("over_writes", n_we - we0, 66);
    end_pkt();
    check("over_dd", n_dd - dd0, 0);

    tv0 = n_tv;
    start_pkt();
    send(8'h80);
    send(8'hE1);
    send(8'h03);
    rst = 1'b1;
    cyc(1);
    check("mid_rcving", rcving, 0);
    check("mid_pid", pid, 0);
    check("mid_endp", token_endp, 0);
    check("mid_bc", byte_count, 0);
    check("mid_err", r_error, 0);
    check("mid_wen", w_enable, 0);
    rst = 1'b0;
    cyc(2);
    check("mid_no_tv", n_tv - tv0, 0);
    token(8'hE1, 8'h03, 8'h50);
    check("post_tv", n_tv - tv0, 1);
    check("post_pid", pid, 1);
    check("post_err", r_error, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
